// File: rtl/sample_stim_gen.sv
// Decimated stimulus sample generator: divides the clock by max(cycle,1), forms a
// sample from an LFSR, ramp or constant on each tick, and holds it for a ready/valid consumer.
module sample_stim_gen #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 5,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  cycle,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  phase,
    output logic              sample_tick,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    output logic [31:0]       sample_count,
    output logic              overrun
);

    typedef enum logic [1:0] {
        SRC_LFSR     = 2'd0,
        SRC_RAMP     = 2'd1,
        SRC_CONST    = 2'd2,
        SRC_LFSR_REV = 2'd3
    } src_t;

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [DATA_W-1:0] ramp;
    logic [CNT_W-1:0]  n_eff;
    logic [CNT_W-1:0]  phase_last;
    logic [CNT_W-1:0]  phase_next;
    logic [DATA_W-1:0] lfsr_rev;
    logic [DATA_W-1:0] candidate;
    src_t              src;

    assign src         = src_t'(mode);
    assign sample_tick = enable && (phase == '0);

    always_comb begin
        n_eff      = (cycle == '0) ? CNT_W'(1) : cycle;
        phase_last = n_eff - CNT_W'(1);
        phase_next = phase;
        // Compare with >= so a shrinking cycle wraps at once instead of running to overflow.
        if (enable) begin
            if (phase >= phase_last) begin
                phase_next = '0;
            end else begin
                phase_next = phase + CNT_W'(1);
            end
        end
    end

    always_comb begin
        lfsr_next = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_next = (lfsr >> 1) ^ LFSR_MASK;
        end
    end

    always_comb begin
        lfsr_rev = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            lfsr_rev[i] = lfsr[DATA_W-1-i];
        end
    end

    always_comb begin
        candidate = '0;
        unique case (src)
            SRC_LFSR:     candidate = lfsr[DATA_W-1:0];
            SRC_RAMP:     candidate = ramp;
            SRC_CONST:    candidate = const_val;
            SRC_LFSR_REV: candidate = lfsr_rev;
            default:      candidate = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= '0;
            lfsr         <= SEED_EFF;
            ramp         <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
            overrun      <= 1'b0;
        end else begin
            phase <= phase_next;
            if (sample_tick) begin
                sample_count <= sample_count + 32'd1;
                if (src == SRC_LFSR || src == SRC_LFSR_REV) begin
                    lfsr <= lfsr_next;
                end
                if (src == SRC_RAMP) begin
                    ramp <= ramp + DATA_W'(1);
                end
                // A slot frees up either because nothing is pending or it is being accepted now.
                if (!sample_valid || out_ready) begin
                    sample_data  <= candidate;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && out_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule
